// File: rtl/load_store_unit_pkg.sv
// lsu_types: types and helper functions shared by the load/store unit files.
// When LSU_MISALIGN_TRAP_EN is defined, misaligned half/word accesses trap
// (see is_misaligned) and issue no cache access.
package lsu_types;

  // Access sequencing: wait for a request, wait for the cache, then report.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } lsu_state_t;

  // Store width, taken from funct3 of the store instruction.
  typedef enum logic [2:0] {
    ST_SB = 3'b000,
    ST_SH = 3'b001,
    ST_SW = 3'b010
  } store_funct3_t;

  // Writeback mux select. The load encodings are the ones this unit extends.
  typedef enum logic [3:0] {
    RF_ALU_OUT  = 4'd0,
    RF_BR_EN    = 4'd1,
    RF_U_IMM    = 4'd2,
    RF_LW       = 4'd3,
    RF_PC_PLUS4 = 4'd4,
    RF_LB       = 4'd5,
    RF_LBU      = 4'd6,
    RF_LH       = 4'd7,
    RF_LHU      = 4'd8
  } regfilemux_sel_t;

  localparam logic [3:0] MBE_ALL = 4'b1111;

  // Byte enables for a store. Halfword lane uses addr[1] only.
  // Unknown widths are treated as full-word stores.
  function automatic logic [3:0] store_mbe(input logic [2:0] funct3,
                                           input logic [1:0] off);
    logic [3:0] m;
    case (store_funct3_t'(funct3))
      ST_SB:   m = 4'b0001 << off;
      ST_SH:   m = off[1] ? 4'b1100 : 4'b0011;
      default: m = MBE_ALL;
    endcase
    return m;
  endfunction

  // Replicate store data across all lanes so the mask alone picks the bytes.
  function automatic logic [31:0] store_wdata(input logic [2:0]  funct3,
                                              input logic [31:0] wdata);
    logic [31:0] w;
    case (store_funct3_t'(funct3))
      ST_SB:   w = {4{wdata[7:0]}};
      ST_SH:   w = {2{wdata[15:0]}};
      default: w = wdata;
    endcase
    return w;
  endfunction

  // True when the access cannot be served inside one naturally aligned lane.
  // Stores are judged by funct3, loads by their writeback select.
  function automatic logic is_misaligned(input logic       is_store,
                                         input logic [2:0] funct3,
                                         input logic [3:0] wb_sel,
                                         input logic [1:0] off);
    logic bad;
    bad = 1'b0;
    if (is_store) begin
      case (store_funct3_t'(funct3))
        ST_SH:   bad = off[0];
        ST_SW:   bad = (off != 2'b00);
        default: bad = 1'b0;
      endcase
    end else begin
      case (regfilemux_sel_t'(wb_sel))
        RF_LH, RF_LHU: bad = off[0];
        RF_LW:         bad = (off != 2'b00);
        default:       bad = 1'b0;
      endcase
    end
    return bad;
  endfunction

endpackage

// File: rtl/load_store_unit_load_extend.sv
// load_extend: selects the addressed byte/halfword of a cache read word and
// sign- or zero-extends it according to the writeback select. Purely
// combinational; non-load selects pass the word through unchanged.
module load_extend
  import lsu_types::*;
(
  input  logic [31:0] rdata_i,
  input  logic [1:0]  off_i,
  input  logic [3:0]  wb_sel_i,
  output logic [31:0] data_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Pick the lane from the low address bits, then extend by load kind.
  always_comb begin
    byte_sel = rdata_i[{off_i, 3'b000} +: 8];
    half_sel = rdata_i[{off_i[1], 4'b0000} +: 16];
    case (regfilemux_sel_t'(wb_sel_i))
      RF_LB:   data_o = {{24{byte_sel[7]}}, byte_sel};
      RF_LBU:  data_o = {24'd0, byte_sel};
      RF_LH:   data_o = {{16{half_sel[15]}}, half_sel};
      RF_LHU:  data_o = {16'd0, half_sel};
      default: data_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: MEM-stage data-memory engine. Takes one load/store per
// handshake, drives a word-aligned cache request with byte mask, waits for
// dmem_resp, then pulses wb_valid with the extended load value.
// Optional feature: define LSU_MISALIGN_TRAP_EN to add the misalign output
// and trap misaligned half/word accesses without touching the cache.
// TIMEOUT_CYC > 0 enables a watchdog on the wait for dmem_resp.
module load_store_unit
  import lsu_types::*;
#(
  parameter int unsigned TIMEOUT_CYC = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_read,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [2:0]  req_funct3,
  input  logic [3:0]  req_wb_sel,
  output logic        dmem_read,
  output logic        dmem_write,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_mbe,
  input  logic        dmem_resp,
  input  logic [31:0] dmem_rdata,
  output logic        wb_valid,
  output logic [31:0] wb_data,
  output logic [3:0]  wb_sel,
  output logic        stall,
  output logic        timeout
`ifdef LSU_MISALIGN_TRAP_EN
  ,
  output logic        misalign
`endif
);

  localparam bit          WDOG_EN   = (TIMEOUT_CYC != 0);
  localparam logic [31:0] WDOG_LAST = WDOG_EN ? 32'(TIMEOUT_CYC - 1) : 32'd0;

  lsu_state_t  state_q, state_d;
  logic [29:0] addr_q, addr_d;
  logic [1:0]  off_q, off_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  mbe_q, mbe_d;
  logic        rd_q, rd_d;
  logic        wr_q, wr_d;
  logic [3:0]  wb_sel_q, wb_sel_d;
  logic [31:0] wb_data_q, wb_data_d;
  logic [31:0] cnt_q, cnt_d;
  logic        timeout_q, timeout_d;
`ifdef LSU_MISALIGN_TRAP_EN
  logic        misalign_q, misalign_d;
`endif

  logic [31:0] ext_data;
  logic        trap;

  // Extension works on the captured offset/select and the live cache word,
  // so the result is ready in the dmem_resp cycle.
  load_extend u_load_extend (
    .rdata_i  (dmem_rdata),
    .off_i    (off_q),
    .wb_sel_i (wb_sel_q),
    .data_o   (ext_data)
  );

`ifdef LSU_MISALIGN_TRAP_EN
  assign trap = is_misaligned(req_write, req_funct3, req_wb_sel, req_addr[1:0]);
`else
  assign trap = 1'b0;
`endif

  // Next-state and captured-value logic for the access sequence.
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    off_d     = off_q;
    wdata_d   = wdata_q;
    mbe_d     = mbe_q;
    rd_d      = rd_q;
    wr_d      = wr_q;
    wb_sel_d  = wb_sel_q;
    wb_data_d = wb_data_q;
    cnt_d     = cnt_q;
    timeout_d = timeout_q;
`ifdef LSU_MISALIGN_TRAP_EN
    misalign_d = misalign_q;
`endif
    case (state_q)
      IDLE: begin
        // A valid op with neither read nor write is not a memory access.
        if (req_valid && (req_read || req_write)) begin
          addr_d    = req_addr[31:2];
          off_d     = req_addr[1:0];
          wb_sel_d  = req_wb_sel;
          // Write wins when both are set.
          wr_d      = req_write;
          rd_d      = ~req_write;
          mbe_d     = req_write ? store_mbe(req_funct3, req_addr[1:0]) : MBE_ALL;
          wdata_d   = req_write ? store_wdata(req_funct3, req_wdata) : 32'd0;
          wb_data_d = 32'd0;
          cnt_d     = 32'd0;
          state_d   = BUSY;
          if (trap) begin
            // Misaligned: skip the cache entirely and report straight away.
            rd_d    = 1'b0;
            wr_d    = 1'b0;
            state_d = DONE;
`ifdef LSU_MISALIGN_TRAP_EN
            misalign_d = 1'b1;
`endif
          end
        end
      end
      BUSY: begin
        if (dmem_resp) begin
          // A response always beats the watchdog, even on its last cycle.
          rd_d      = 1'b0;
          wr_d      = 1'b0;
          wb_data_d = wr_q ? 32'd0 : ext_data;
          state_d   = DONE;
        end else if (WDOG_EN && (cnt_q == WDOG_LAST)) begin
          rd_d      = 1'b0;
          wr_d      = 1'b0;
          wb_data_d = 32'd0;
          timeout_d = 1'b1;
          state_d   = DONE;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      DONE: begin
        state_d = IDLE;
`ifdef LSU_MISALIGN_TRAP_EN
        misalign_d = 1'b0;
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers; reset drops any access in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      off_q     <= '0;
      wdata_q   <= '0;
      mbe_q     <= '0;
      rd_q      <= 1'b0;
      wr_q      <= 1'b0;
      wb_sel_q  <= '0;
      wb_data_q <= '0;
      cnt_q     <= '0;
      timeout_q <= 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
      misalign_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      off_q     <= off_d;
      wdata_q   <= wdata_d;
      mbe_q     <= mbe_d;
      rd_q      <= rd_d;
      wr_q      <= wr_d;
      wb_sel_q  <= wb_sel_d;
      wb_data_q <= wb_data_d;
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
`ifdef LSU_MISALIGN_TRAP_EN
      misalign_q <= misalign_d;
`endif
    end
  end

  assign req_ready  = (state_q == IDLE);
  assign stall      = (state_q != IDLE);
  assign wb_valid   = (state_q == DONE);
  assign dmem_read  = rd_q;
  assign dmem_write = wr_q;
  assign dmem_addr  = {addr_q, 2'b00};
  assign dmem_wdata = wdata_q;
  assign dmem_mbe   = mbe_q;
  assign wb_data    = wb_data_q;
  assign wb_sel     = wb_sel_q;
  assign timeout    = timeout_q;
`ifdef LSU_MISALIGN_TRAP_EN
  assign misalign   = misalign_q;
`endif

endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: directed plus randomized checks of load_store_unit
// against a behavioural model of the access rules (watchdog set to 8).
module tb_load_store_unit;
  import lsu_types::*;

  localparam int unsigned TO = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_valid = 1'b0, req_read = 1'b0, req_write = 1'b0;
  logic        req_ready;
  logic [31:0] req_addr = '0, req_wdata = '0;
  logic [2:0]  req_funct3 = '0;
  logic [3:0]  req_wb_sel = '0;
  logic        dmem_read, dmem_write;
  logic [31:0] dmem_addr, dmem_wdata;
  logic [3:0]  dmem_mbe;
  logic        dmem_resp = 1'b0;
  logic [31:0] dmem_rdata = '0;
  logic        wb_valid, stall, timeout;
  logic [31:0] wb_data;
  logic [3:0]  wb_sel;
`ifdef LSU_MISALIGN_TRAP_EN
  logic        misalign;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  load_store_unit #(.TIMEOUT_CYC(TO)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_read   (req_read),
    .req_write  (req_write),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .req_funct3 (req_funct3),
    .req_wb_sel (req_wb_sel),
    .dmem_read  (dmem_read),
    .dmem_write (dmem_write),
    .dmem_addr  (dmem_addr),
    .dmem_wdata (dmem_wdata),
    .dmem_mbe   (dmem_mbe),
    .dmem_resp  (dmem_resp),
    .dmem_rdata (dmem_rdata),
    .wb_valid   (wb_valid),
    .wb_data    (wb_data),
    .wb_sel     (wb_sel),
    .stall      (stall),
    .timeout    (timeout)
`ifdef LSU_MISALIGN_TRAP_EN
    ,
    .misalign   (misalign)
`endif
  );

  task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // ---- reference model: arithmetic on the access rules ----
  function automatic logic [31:0] model_load(input logic [31:0] rdata,
                                             input logic [31:0] addr,
                                             input logic [3:0] sel);
    int unsigned off  = addr % 4;
    int unsigned hoff = (addr / 2) % 2;
    int v;
    if (sel == RF_LB || sel == RF_LBU) begin
      v = int'((rdata >> (8 * off)) & 32'hFF);
      if (sel == RF_LB && v >= 128) v = v - 256;
    end else if (sel == RF_LH || sel == RF_LHU) begin
      v = int'((rdata >> (16 * hoff)) & 32'hFFFF);
      if (sel == RF_LH && v >= 32768) v = v - 65536;
    end else begin
      v = int'(rdata);
    end
    return 32'(v);
  endfunction

  function automatic logic [3:0] model_mbe(input bit wr, input logic [2:0] f3,
                                           input logic [31:0] addr);
    if (!wr) return 4'hF;
    if (f3 == 3'd0) return 4'(1 << (addr % 4));
    if (f3 == 3'd1) return 4'(3 << (2 * ((addr / 2) % 2)));
    return 4'hF;
  endfunction

  function automatic logic [31:0] model_wdata(input logic [2:0] f3, input logic [31:0] w);
    if (f3 == 3'd0) return (w & 32'hFF) * 32'h0101_0101;
    if (f3 == 3'd1) return (w & 32'hFFFF) * 32'h0001_0001;
    return w;
  endfunction

  function automatic bit model_trap(input bit wr, input logic [2:0] f3,
                                    input logic [3:0] sel, input logic [31:0] addr);
`ifdef LSU_MISALIGN_TRAP_EN
    if (wr) return (f3 == 3'd1 && addr % 2 != 0) || (f3 == 3'd2 && addr % 4 != 0);
    return ((sel == RF_LH || sel == RF_LHU) && addr % 2 != 0) ||
           (sel == RF_LW && addr % 4 != 0);
`else
    return 1'b0;
`endif
  endfunction

  // One complete access. Starts and ends at a negedge inside an IDLE cycle.
  // n = cycles from the first strobe cycle to the dmem_resp cycle.
  task automatic access(input string tag, input bit rd, input bit wr,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [2:0] f3, input logic [3:0] sel,
                        input logic [31:0] rdata, input int n,
                        output logic [31:0] obs_wb);
    logic [3:0]  exp_mbe;
    logic [31:0] exp_wd, exp_wb;
    bit          trap;
    exp_mbe = model_mbe(wr, f3, addr);
    exp_wd  = model_wdata(f3, wdata);
    exp_wb  = wr ? 32'd0 : model_load(rdata, addr, sel);
    trap    = model_trap(wr, f3, sel, addr);

    check1({tag, " ready"}, req_ready, 1'b1);
    req_valid = 1'b1; req_read = rd; req_write = wr; req_addr = addr;
    req_wdata = wdata; req_funct3 = f3; req_wb_sel = sel;
    @(posedge clk);
    @(negedge clk);
    // Upstream keeps presenting a follow-on op; it must not be taken early.
    req_read = 1'b1; req_write = 1'(($urandom) & 1); req_addr = $urandom;
    req_wdata = $urandom; req_funct3 = 3'($urandom_range(0, 2));
    req_wb_sel = 4'($urandom_range(0, 8));
    if (trap) begin
      check1({tag, " trap wb_valid"}, wb_valid, 1'b1);
      check1({tag, " trap rd"}, dmem_read, 1'b0);
      check1({tag, " trap wr"}, dmem_write, 1'b0);
      check32({tag, " trap wb_data"}, wb_data, 32'd0);
`ifdef LSU_MISALIGN_TRAP_EN
      check1({tag, " trap misalign"}, misalign, 1'b1);
`endif
    end else begin
      for (int k = 1; k <= n + 1; k++) begin
        check1($sformatf("%s b%0d rd", tag, k), dmem_read, rd && !wr);
        check1($sformatf("%s b%0d wr", tag, k), dmem_write, wr);
        check32($sformatf("%s b%0d addr", tag, k), dmem_addr, addr & ~32'h3);
        check32($sformatf("%s b%0d mbe", tag, k), {28'd0, dmem_mbe}, {28'd0, exp_mbe});
        if (wr) check32($sformatf("%s b%0d wdata", tag, k), dmem_wdata, exp_wd);
        check1($sformatf("%s b%0d stall", tag, k), stall, 1'b1);
        check1($sformatf("%s b%0d ready", tag, k), req_ready, 1'b0);
        check1($sformatf("%s b%0d wb_valid", tag, k), wb_valid, 1'b0);
        if (k == n + 1) begin
          dmem_resp = 1'b1;
          dmem_rdata = rdata;
        end
        @(negedge clk);
      end
      dmem_resp = 1'b0;
      dmem_rdata = $urandom;
      check1({tag, " wb_valid"}, wb_valid, 1'b1);
      check32({tag, " wb_data"}, wb_data, exp_wb);
      check1({tag, " done rd"}, dmem_read, 1'b0);
      check1({tag, " done wr"}, dmem_write, 1'b0);
      check1({tag, " done stall"}, stall, 1'b1);
      check1({tag, " timeout"}, timeout, 1'b0);
`ifdef LSU_MISALIGN_TRAP_EN
      check1({tag, " misalign"}, misalign, 1'b0);
`endif
    end
    check32({tag, " wb_sel"}, {28'd0, wb_sel}, {28'd0, sel});
    check1({tag, " done ready"}, req_ready, 1'b0);
    obs_wb = wb_data;
    @(negedge clk);
    check1({tag, " idle wb_valid"}, wb_valid, 1'b0);
    check1({tag, " idle stall"}, stall, 1'b0);
    $display("access %s rd=%0b wr=%0b addr=%h wb_data=%h", tag, rd, wr, addr, obs_wb);
    req_valid = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global time limit reached");
    $fatal(1);
  end

  initial begin
    logic [31:0] obs;
    bit rd, wr;
    logic [31:0] a;
    logic [3:0]  sel;

    // Reset state
    repeat (2) @(negedge clk);
    check1("rst ready", req_ready, 1'b1);
    check1("rst stall", stall, 1'b0);
    check1("rst rd", dmem_read, 1'b0);
    check1("rst wr", dmem_write, 1'b0);
    check1("rst wb_valid", wb_valid, 1'b0);
    check32("rst wb_data", wb_data, 32'd0);
    check1("rst timeout", timeout, 1'b0);
`ifdef LSU_MISALIGN_TRAP_EN
    check1("rst misalign", misalign, 1'b0);
`endif
    rst = 1'b1;
    @(negedge clk);

    // Directed cases
    access("lb_103", 1, 0, 32'h103, 32'h0, 3'd0, RF_LB, 32'h80FF_1234, 2, obs);
    check32("lb_103 literal", obs, 32'hFFFF_FF80);
    access("lhu_202", 1, 0, 32'h202, 32'h0, 3'd0, RF_LHU, 32'hBEEF_0000, 1, obs);
    check32("lhu_202 literal", obs, 32'h0000_BEEF);
    access("sb_301", 0, 1, 32'h301, 32'h0000_00AB, 3'd0, RF_ALU_OUT, 32'h1234_5678, 1, obs);
    access("rw_both", 1, 1, 32'h402, 32'hCAFE_F00D, 3'd1, RF_LW, 32'h1111_2222, 3, obs);
    access("lw_other", 1, 0, 32'h500, 32'h0, 3'd0, RF_U_IMM, 32'hDEAD_BEEF, 1, obs);

    // Valid with neither read nor write is ignored
    req_valid = 1'b1; req_read = 1'b0; req_write = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check1("nop stall", stall, 1'b0);
    check1("nop ready", req_ready, 1'b1);
    check1("nop rd", dmem_read, 1'b0);
    check1("nop wr", dmem_write, 1'b0);
    req_valid = 1'b0;
    $display("nop request ignored check done");

    // Randomized accesses, back-to-back
    for (int i = 0; i < 40; i++) begin
      rd = 1'(($urandom) & 1);
      wr = 1'(($urandom) & 1);
      if (!rd && !wr) rd = 1'b1;
      a = $urandom;
      case ($urandom_range(0, 5))
        0: sel = RF_LW;  1: sel = RF_LB;  2: sel = RF_LBU;
        3: sel = RF_LH;  4: sel = RF_LHU; default: sel = RF_ALU_OUT;
      endcase
      access($sformatf("rnd%0d", i), rd, wr, a, $urandom, 3'($urandom_range(0, 2)),
             sel, $urandom, $urandom_range(1, 6), obs);
    end

`ifdef LSU_MISALIGN_TRAP_EN
    access("mis_lw", 1, 0, 32'h102, 32'h0, 3'd0, RF_LW, 32'h0, 1, obs);
    access("mis_sh", 0, 1, 32'h203, 32'h55AA, 3'd1, RF_ALU_OUT, 32'h0, 1, obs);
`endif

    // Response on the watchdog's last cycle wins
    access("resp_at_limit", 1, 0, 32'h600, 32'h0, 3'd0, RF_LW, 32'h0BAD_F00D, 7, obs);

    // Watchdog: no response at all
    req_valid = 1'b1; req_read = 1'b1; req_write = 1'b0; req_addr = 32'h700;
    req_wb_sel = RF_LW; req_funct3 = 3'd2;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    for (int k = 1; k <= int'(TO); k++) begin
      check1($sformatf("wdog b%0d timeout", k), timeout, 1'b0);
      check1($sformatf("wdog b%0d rd", k), dmem_read, 1'b1);
      check1($sformatf("wdog b%0d wb_valid", k), wb_valid, 1'b0);
      @(negedge clk);
    end
    check1("wdog wb_valid", wb_valid, 1'b1);
    check32("wdog wb_data", wb_data, 32'd0);
    check1("wdog timeout", timeout, 1'b1);
    check1("wdog rd", dmem_read, 1'b0);
    @(negedge clk);
    check1("wdog sticky", timeout, 1'b1);
    check1("wdog idle ready", req_ready, 1'b1);
    $display("watchdog timeout=%0b", timeout);

    // Asynchronous reset in the middle of BUSY
    req_valid = 1'b1; req_read = 1'b0; req_write = 1'b1; req_addr = 32'h800;
    req_wdata = 32'h1234_5678; req_funct3 = 3'd2; req_wb_sel = RF_ALU_OUT;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    check1("mid wr before rst", dmem_write, 1'b1);
    #2 rst = 1'b0;
    #1;
    check1("mid rst wr", dmem_write, 1'b0);
    check1("mid rst rd", dmem_read, 1'b0);
    check1("mid rst stall", stall, 1'b0);
    check1("mid rst wb_valid", wb_valid, 1'b0);
    check1("mid rst timeout", timeout, 1'b0);
    check1("mid rst ready", req_ready, 1'b1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check1("post rst ready", req_ready, 1'b1);
    $display("reset mid-busy done");
    access("after_rst", 1, 0, 32'h904, 32'h0, 3'd0, RF_LH, 32'h8001_7FFF, 1, obs);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
